cordic_gain_comp: RTL and testbench

- Downstream stage of the 12-bit CORDIC rotator.
- Takes the rotator's x_out, y_out and theda_out, and removes the CORDIC gain by multiplying x and y by K = 311/512 (≈0.6074).
- The angle passes through unchanged, delay-matched to x and y.
- Two-stage pipeline with valid/ready handshake and full back-pressure. Feeds result capture / file-dump logic.

---
 rtl/cordic_gain_comp.sv | 113 +++++++++++
 tb/tb_cordic_gain_comp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: removes the CORDIC rotator gain from x/y by scaling with
// K = 311/512 and carries the angle through unchanged, delay-matched.
// Two-stage valid/ready pipeline with full back-pressure and a counter of
// results accepted by the consumer.
// Optional build macro CGC_ROUND_EN: round half-up (+256 before the >>>9).
// Without it the scaled result is truncated (floor).
module cordic_gain_comp #(
   parameter int W     = 12,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x_in,
   input  logic [W-1:0]     y_in,
   input  logic [W-1:0]     theda_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     x_comp,
   output logic [W-1:0]     y_comp,
   output logic [W-1:0]     theda_comp,
   output logic [CNT_W-1:0] out_cnt
);

   // Products up to 2048*320 need W+9 bits signed.
   localparam int PW = W + 9;

`ifdef CGC_ROUND_EN
   localparam logic signed [PW-1:0] HALF = PW'(256);
`endif

   logic                 v1, v2;
   logic                 en1, en2;
   logic signed [PW-1:0] xe, ye;
   logic signed [PW-1:0] ax_d, bx_d, ay_d, by_d;
   logic signed [PW-1:0] ax, bx, ay, by;
   logic        [W-1:0]  th1;
   logic signed [PW-1:0] rx, ry;

   // Pipeline advance: a stage may load when empty or when the one after it moves.
   always_comb begin
      en2       = ~v2 | out_ready;
      en1       = ~v1 | en2;
      in_ready  = en1 & rst_n;
      out_valid = v2;
   end

   // Stage-1 partial products: a = x*320, b = x*9, so a - b = x*311.
   always_comb begin
      xe   = {{9{x_in[W-1]}}, x_in};
      ye   = {{9{y_in[W-1]}}, y_in};
      ax_d = (xe <<< 8) + (xe <<< 6);
      bx_d = (xe <<< 3) + xe;
      ay_d = (ye <<< 8) + (ye <<< 6);
      by_d = (ye <<< 3) + ye;
   end

   // Stage-2 combine: x*311, optionally biased by half an LSB of the /512.
   always_comb begin
`ifdef CGC_ROUND_EN
      rx = ax - bx + HALF;
      ry = ay - by + HALF;
`else
      rx = ax - bx;
      ry = ay - by;
`endif
   end

   // Stage-1 registers: partial products and angle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1  <= 1'b0;
         ax  <= '0;
         bx  <= '0;
         ay  <= '0;
         by  <= '0;
         th1 <= '0;
      end else if (en1) begin
         v1  <= in_valid;
         ax  <= ax_d;
         bx  <= bx_d;
         ay  <= ay_d;
         by  <= by_d;
         th1 <= theda_in;
      end
   end

   // Stage-2 registers: arithmetic shift by 9 (floor) gives the scaled output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2         <= 1'b0;
         x_comp     <= '0;
         y_comp     <= '0;
         theda_comp <= '0;
      end else if (en2) begin
         v2         <= v1;
         x_comp     <= W'(rx >>> 9);
         y_comp     <= W'(ry >>> 9);
         theda_comp <= th1;
      end
   end

   // Count output transfers; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_cnt <= '0;
      end else if (v2 && out_ready) begin
         out_cnt <= out_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp: directed-vector bench for cordic_gain_comp.
// Expected values are hand-computed (x*311/512, floor or round-half-up
// depending on CGC_ROUND_EN). A second instance with CNT_W=4 checks wrap.
module tb_cordic_gain_comp;

   localparam int W = 12;

`ifdef CGC_ROUND_EN
   localparam int M1000 = -607;
   localparam int R1    = 1;
`else
   localparam int M1000 = -608;
   localparam int R1    = 0;
`endif

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  x_in      = '0;
   logic [W-1:0]  y_in      = '0;
   logic [W-1:0]  theda_in  = '0;

   logic          in_ready, out_valid;
   logic [W-1:0]  x_comp, y_comp, theda_comp;
   logic [15:0]   out_cnt;

   logic          in_ready4, out_valid4;
   logic [W-1:0]  x_comp4, y_comp4, theda_comp4;
   logic [3:0]    out_cnt4;

   int total = 0;
   int bad   = 0;

   int tx[12] = '{  512,  1024,  1536, -2048,  1000,    1,    0,  -512, -1024, -1536,  2047, -1000};
   int ty[12] = '{ -512, -1024, -1536,  2047, -1000,   -1,    0,   512,  1024,  1536, -2048,  1000};
   int tt[12] = '{-2048,    -1,     0,     1,   300, 2047, -300,  1234, -1234,    77, -2048,     5};
   int ex[12] = '{  311,   622,   933, -1244,   607,   R1,    0,  -311,  -622,  -933,  1243, M1000};
   int ey[12] = '{ -311,  -622,  -933,  1243, M1000,   -1,    0,   311,   622,   933, -1244,   607};

   cordic_gain_comp #(.W(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .theda_in(theda_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_comp(x_comp), .y_comp(y_comp), .theda_comp(theda_comp),
      .out_cnt(out_cnt)
   );

   cordic_gain_comp #(.W(W), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready4),
      .x_in(x_in), .y_in(y_in), .theda_in(theda_in),
      .out_valid(out_valid4), .out_ready(out_ready),
      .x_comp(x_comp4), .y_comp(y_comp4), .theda_comp(theda_comp4),
      .out_cnt(out_cnt4)
   );

   always #5 clk = ~clk;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold reset for n edges with a live input offered; everything must read zero.
   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      x_in = W'(123); y_in = W'(-77); theda_in = W'(55);
      #1 check("rst in_ready", int'(in_ready), 0);
      repeat (n) @(negedge clk);
      #1;
      check("rst in_ready hold", int'(in_ready), 0);
      check("rst out_valid", int'(out_valid), 0);
      check("rst x_comp", sx(x_comp), 0);
      check("rst y_comp", sx(y_comp), 0);
      check("rst theda_comp", sx(theda_comp), 0);
      check("rst out_cnt", int'(out_cnt), 0);
      check("rst4 in_ready", int'(in_ready4), 0);
      check("rst4 out_valid", int'(out_valid4), 0);
      check("rst4 data", sx(x_comp4) + sx(y_comp4) + sx(theda_comp4), 0);
      check("rst4 out_cnt", int'(out_cnt4), 0);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   // One isolated sample: checks latency of two edges and the result.
   task automatic single(input int x, input int y, input int th,
                         input int exx, input int exy, input int cnt, input string tag);
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      x_in = W'(x); y_in = W'(y); theda_in = W'(th);
      #1 check({tag, " in_ready"}, int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check({tag, " valid after 1"}, int'(out_valid), 0);
      @(negedge clk);
      #1;
      check({tag, " valid after 2"}, int'(out_valid), 1);
      check({tag, " x"}, sx(x_comp), exx);
      check({tag, " y"}, sx(y_comp), exy);
      check({tag, " theda"}, sx(theda_comp), th);
      @(negedge clk);
      #1;
      check({tag, " out_cnt"}, int'(out_cnt), cnt);
      check({tag, " valid drop"}, int'(out_valid), 0);
   endtask

   // Stream n table samples; out_ready is low on stream cycles stall_lo..stall_hi.
   task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                             input string tag, output int cycles);
      int in_idx = 0;
      int out_idx = 0;
      int cyc = 0;
      int occ;
      logic held = 1'b0;
      int hx = 0, hy = 0, ht = 0;
      while (out_idx < n && cyc < 200) begin
         @(negedge clk);
         out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         in_valid  = (in_idx < n);
         if (in_idx < n) begin
            x_in = W'(tx[in_idx % 12]);
            y_in = W'(ty[in_idx % 12]);
            theda_in = W'(tt[in_idx % 12]);
         end
         #1;
         occ = in_idx - out_idx;
         check($sformatf("%s in_ready c%0d", tag, cyc), int'(in_ready),
               (occ == 2 && !out_ready) ? 0 : 1);
         if (held) begin
            check($sformatf("%s stall valid c%0d", tag, cyc), int'(out_valid), 1);
            check($sformatf("%s stall x c%0d", tag, cyc), sx(x_comp), hx);
            check($sformatf("%s stall y c%0d", tag, cyc), sx(y_comp), hy);
            check($sformatf("%s stall t c%0d", tag, cyc), sx(theda_comp), ht);
         end
         held = out_valid && !out_ready;
         hx = sx(x_comp); hy = sx(y_comp); ht = sx(theda_comp);
         if (out_valid && out_ready) begin
            check($sformatf("%s x[%0d]", tag, out_idx), sx(x_comp), ex[out_idx % 12]);
            check($sformatf("%s y[%0d]", tag, out_idx), sx(y_comp), ey[out_idx % 12]);
            check($sformatf("%s t[%0d]", tag, out_idx), sx(theda_comp), tt[out_idx % 12]);
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         cyc++;
      end
      check({tag, " all results"}, out_idx, n);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1 check({tag, " drained"}, int'(out_valid), 0);
      cycles = cyc;
   endtask

   initial begin
      int cycles;

      // Reset with in_valid high for 3 cycles.
      do_reset(3);

      // Single samples and arithmetic extremes.
      single(1000, -1000, 300, 607, M1000, 1, "s1000");
      single(2047, -2048, -2048, 1243, -1244, 2, "sext");
      single(-1000, 1000, -5, M1000, 607, 3, "sneg");
      single(1, -1, 7, R1, -1, 4, "sone");

      // Back-pressure: out_ready low on stream cycles 3..7.
      do_reset(1);
      run_stream(12, 3, 7, "bp", cycles);
      check("bp out_cnt", int'(out_cnt), 12);

      // Full rate: 12 results in 14 cycles (2 fill + 12).
      do_reset(1);
      run_stream(12, -1, -1, "full", cycles);
      check("full cycles", cycles, 14);
      check("full out_cnt", int'(out_cnt), 12);

      // Mid-stream reset with two samples in flight.
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      x_in = W'(tx[0]); y_in = W'(ty[0]); theda_in = W'(tt[0]);
      @(negedge clk);
      x_in = W'(tx[1]); y_in = W'(ty[1]); theda_in = W'(tt[1]);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      #1;
      check("mid in_ready in rst", int'(in_ready), 0);
      check("mid out_valid pre", int'(out_valid), 1);
      check("mid x pre", sx(x_comp), 311);
      check("mid cnt pre", int'(out_cnt), 12);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid out_valid post", int'(out_valid), 0);
      check("mid out_cnt post", int'(out_cnt), 0);
      check("mid x post", sx(x_comp), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check($sformatf("mid no output %0d", i), int'(out_valid), 0);
      end
      check("mid cnt stays", int'(out_cnt), 0);

      // Counter wrap: 17 transfers, CNT_W=4 instance reads 1.
      do_reset(1);
      run_stream(17, -1, -1, "wrap", cycles);
      check("wrap out_cnt16", int'(out_cnt), 17);
      check("wrap out_cnt4", int'(out_cnt4), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
